avaliador_jogada: RTL

- Sequential front end that produces the per-round inputs of the score calculator and closes the loop on its result.
- Walks each round note by note and compares each played note with the expected note.
- Counts mispressed notes as errors, then issues a one-cycle `calcular` strobe with `rodada`/`erros`/`pontos_in`.
- Registers the returned `pontos_out` as the running game score.
- Sits between the keypad/note-memory logic and the score calculator.

---
 rtl/avaliador_jogada.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/avaliador_jogada.sv
// Round evaluator: walks each round note by note, counts errors, and feeds the score calculator.
// Optional PENALIDADE_TEMPO_EN adds a per-note timeout that counts a missing note as an error.
module avaliador_jogada #(
    parameter logic [3:0] ULTIMA_RODADA  = 4'hF,
    parameter logic [7:0] ERROS_MAX      = 8'hFF,
    parameter int         TIMEOUT_CICLOS = 1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       nota_valida,
    input  logic [3:0] nota_tocada,
    input  logic [3:0] nota_esperada,
    input  logic [7:0] pontos_calc,
    output logic [3:0] indice,
    output logic [3:0] rodada,
    output logic [7:0] erros,
    output logic [7:0] pontos_in,
    output logic       calcular,
    output logic       rodada_fim,
    output logic       jogo_fim,
    output logic       ocupado
);

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_NOTA,
        CALCULA,
        REGISTRA,
        FIM
    } estado_t;

    estado_t    estado_q, estado_d;
    logic [3:0] indice_q, indice_d;
    logic [3:0] rodada_q, rodada_d;
    logic [7:0] erros_q, erros_d;
    logic [7:0] pontos_q, pontos_d;
    logic       calcular_q, calcular_d;
    logic       rodada_fim_q, rodada_fim_d;
    logic       jogo_fim_q, jogo_fim_d;
    logic       ocupado_q, ocupado_d;
    logic       estouro;
    logic       nota_evt;
    logic       erro_evt;

`ifdef PENALIDADE_TEMPO_EN
    localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    logic [TW-1:0] tempo_q, tempo_d;

    assign estouro = (estado_q == ESPERA_NOTA) && !nota_valida &&
                     (tempo_q == TW'(TIMEOUT_CICLOS - 1));

    // Timer only runs while waiting in ESPERA_NOTA; any note or state change restarts it
    always_comb begin
        tempo_d = tempo_q + TW'(1);
        if (estado_q != ESPERA_NOTA || estado_d != estado_q ||
            nota_valida || estouro) begin
            tempo_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tempo_q <= '0;
        end else begin
            tempo_q <= tempo_d;
        end
    end
`else
    assign estouro = 1'b0;
`endif

    assign nota_evt = nota_valida || estouro;
    assign erro_evt = (nota_valida && (nota_tocada != nota_esperada)) || estouro;

    always_comb begin
        estado_d = estado_q;
        indice_d = indice_q;
        rodada_d = rodada_q;
        erros_d  = erros_q;
        pontos_d = pontos_q;
        unique case (estado_q)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    estado_d = ESPERA_NOTA;
                    indice_d = '0;
                    rodada_d = '0;
                    erros_d  = '0;
                    pontos_d = '0;
                end
            end
            ESPERA_NOTA: begin
                if (nota_evt) begin
                    if (erro_evt && erros_q != ERROS_MAX) begin
                        erros_d = erros_q + 8'd1;
                    end
                    if (indice_q == rodada_q) begin
                        estado_d = CALCULA;
                    end else begin
                        indice_d = indice_q + 4'd1;
                    end
                end
            end
            CALCULA: begin
                estado_d = REGISTRA;
                pontos_d = pontos_calc;
            end
            REGISTRA: begin
                if (rodada_q == ULTIMA_RODADA) begin
                    estado_d = FIM;
                end else begin
                    estado_d = ESPERA_NOTA;
                    rodada_d = rodada_q + 4'd1;
                    erros_d  = '0;
                    indice_d = '0;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Status flags are decoded from the next state so they are registered with it
    always_comb begin
        calcular_d   = (estado_d == CALCULA);
        rodada_fim_d = (estado_d == REGISTRA);
        jogo_fim_d   = (estado_d == FIM);
        ocupado_d    = (estado_d != OCIOSO) && (estado_d != FIM);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= OCIOSO;
            indice_q     <= '0;
            rodada_q     <= '0;
            erros_q      <= '0;
            pontos_q     <= '0;
            calcular_q   <= 1'b0;
            rodada_fim_q <= 1'b0;
            jogo_fim_q   <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            indice_q     <= indice_d;
            rodada_q     <= rodada_d;
            erros_q      <= erros_d;
            pontos_q     <= pontos_d;
            calcular_q   <= calcular_d;
            rodada_fim_q <= rodada_fim_d;
            jogo_fim_q   <= jogo_fim_d;
            ocupado_q    <= ocupado_d;
        end
    end

    assign indice     = indice_q;
    assign rodada     = rodada_q;
    assign erros      = erros_q;
    assign pontos_in  = pontos_q;
    assign calcular   = calcular_q;
    assign rodada_fim = rodada_fim_q;
    assign jogo_fim   = jogo_fim_q;
    assign ocupado    = ocupado_q;

endmodule
